// File: rtl/motor_pkg.sv
// Shared definitions for the motor speed stages: state encoding, default
// geometry of the PWM window and the duty clamp helper.
package motor_pkg;

    typedef enum logic [1:0] {
        StStop    = 2'd0,
        StRun     = 2'd1,
        StTimeout = 2'd2
    } state_e;

    localparam int unsigned PERIOD_DEF     = 250;
    localparam int unsigned BASE_SPEED_DEF = 150;
    localparam int unsigned DUTY_W_DEF     = 8;

    // Clamp a signed mixed speed into the legal duty range [0, period].
    function automatic int clamp_duty(input int v, input int period);
        if (v < 0) begin
            return 0;
        end else if (v > period) begin
            return period;
        end
        return v;
    endfunction

    // True when clamp_duty would have changed the value.
    function automatic logic is_clamped(input int v, input int period);
        return (v < 0) || (v > period);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One edge-aligned PWM output. Driven from the next-state counter and duty so
// the registered bit lines up with the counter value it belongs to.
module pwm_channel #(
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic              en_i,
    output logic              pwm_o
);

    logic pwm_q;

    // High for the first duty_i counts of each window while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= en_i && (cnt_i < duty_i);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_pwm_mixer.sv
// Mixes the PID correction into a base speed for two motors, clamps the
// results and drives two PWM channels. Duties only change on window
// boundaries; a watchdog stops the motors when corrections stop arriving.
module motor_pwm_mixer
    import motor_pkg::*;
#(
    parameter int unsigned PERIOD          = motor_pkg::PERIOD_DEF,
    parameter int unsigned BASE_SPEED      = motor_pkg::BASE_SPEED_DEF,
    parameter int unsigned TIMEOUT_PERIODS = 8,
    parameter int unsigned DUTY_W          = motor_pkg::DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        delta,
    input  logic              delta_valid,
    output logic              pwm_left,
    output logic              pwm_right,
    output logic [DUTY_W-1:0] duty_left,
    output logic [DUTY_W-1:0] duty_right,
    output logic              sat_left,
    output logic              sat_right,
    output logic              period_start,
    output logic [1:0]        state
);

    localparam int unsigned SW = DUTY_W + 2;
    localparam int unsigned MW = $clog2(TIMEOUT_PERIODS + 1);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic              pend_sl_q, pend_sl_d, pend_sr_q, pend_sr_d;
    logic              pv_q, pv_d;
    logic [DUTY_W-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic              sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic [MW-1:0]     miss_q, miss_d, miss_inc;
    logic              ps_q, ps_d;

    logic signed [SW-1:0] delta_ext, sum_l, sum_r;
    logic [DUTY_W-1:0]    clamp_l, clamp_r;
    logic                 csat_l, csat_r;
    logic                 boundary;

    // Mix and clamp the incoming correction.
    always_comb begin
        delta_ext = SW'(signed'(delta));
        sum_l     = signed'(SW'(BASE_SPEED)) + delta_ext;
        sum_r     = signed'(SW'(BASE_SPEED)) - delta_ext;
        clamp_l   = DUTY_W'(clamp_duty(int'(sum_l), int'(PERIOD)));
        clamp_r   = DUTY_W'(clamp_duty(int'(sum_r), int'(PERIOD)));
        csat_l    = is_clamped(int'(sum_l), int'(PERIOD));
        csat_r    = is_clamped(int'(sum_r), int'(PERIOD));
    end

    assign boundary = (state_q != StStop) && (cnt_q == DUTY_W'(PERIOD - 1));
    assign miss_inc = miss_q + 1'b1;

    // Next-state: FSM, window counter, pending capture and boundary load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_l_d  = pend_l_q;
        pend_r_d  = pend_r_q;
        pend_sl_d = pend_sl_q;
        pend_sr_d = pend_sr_q;
        pv_d      = pv_q;
        duty_l_d  = duty_l_q;
        duty_r_d  = duty_r_q;
        sat_l_d   = sat_l_q;
        sat_r_d   = sat_r_q;
        miss_d    = miss_q;
        ps_d      = 1'b0;

        if (!enable) begin
            state_d  = StStop;
            cnt_d    = '0;
            pv_d     = 1'b0;
            duty_l_d = '0;
            duty_r_d = '0;
            sat_l_d  = 1'b0;
            sat_r_d  = 1'b0;
            miss_d   = '0;
        end else if (state_q == StStop) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            if (boundary) begin
                cnt_d = '0;
                ps_d  = 1'b1;
                if (pv_q) begin
                    duty_l_d = pend_l_q;
                    duty_r_d = pend_r_q;
                    sat_l_d  = pend_sl_q;
                    sat_r_d  = pend_sr_q;
                    pv_d     = 1'b0;
                    miss_d   = '0;
                end else if (state_q == StRun && !delta_valid) begin
                    // A strobe on the boundary cycle is late, not missing.
                    miss_d = miss_inc;
                    if (miss_inc == MW'(TIMEOUT_PERIODS)) begin
                        state_d  = StTimeout;
                        duty_l_d = '0;
                        duty_r_d = '0;
                        sat_l_d  = 1'b0;
                        sat_r_d  = 1'b0;
                        miss_d   = '0;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // Capture after the boundary load so a same-cycle strobe waits a window.
            if (delta_valid) begin
                pend_l_d  = clamp_l;
                pend_r_d  = clamp_r;
                pend_sl_d = csat_l;
                pend_sr_d = csat_r;
                pv_d      = 1'b1;
                if (state_q == StTimeout) begin
                    state_d = StRun;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StStop;
            cnt_q     <= '0;
            pend_l_q  <= '0;
            pend_r_q  <= '0;
            pend_sl_q <= 1'b0;
            pend_sr_q <= 1'b0;
            pv_q      <= 1'b0;
            duty_l_q  <= '0;
            duty_r_q  <= '0;
            sat_l_q   <= 1'b0;
            sat_r_q   <= 1'b0;
            miss_q    <= '0;
            ps_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_l_q  <= pend_l_d;
            pend_r_q  <= pend_r_d;
            pend_sl_q <= pend_sl_d;
            pend_sr_q <= pend_sr_d;
            pv_q      <= pv_d;
            duty_l_q  <= duty_l_d;
            duty_r_q  <= duty_r_d;
            sat_l_q   <= sat_l_d;
            sat_r_q   <= sat_r_d;
            miss_q    <= miss_d;
            ps_q      <= ps_d;
        end
    end

    pwm_channel #(
        .DUTY_W (DUTY_W)
    ) u_pwm_left (
        .clk    (clk),
        .rst    (rst),
        .cnt_i  (cnt_d),
        .duty_i (duty_l_d),
        .en_i   (state_d == StRun),
        .pwm_o  (pwm_left)
    );

    pwm_channel #(
        .DUTY_W (DUTY_W)
    ) u_pwm_right (
        .clk    (clk),
        .rst    (rst),
        .cnt_i  (cnt_d),
        .duty_i (duty_r_d),
        .en_i   (state_d == StRun),
        .pwm_o  (pwm_right)
    );

    assign duty_left    = duty_l_q;
    assign duty_right   = duty_r_q;
    assign sat_left     = sat_l_q;
    assign sat_right    = sat_r_q;
    assign period_start = ps_q;
    assign state        = state_q;

endmodule

// File: tb/tb_motor_pwm_mixer.sv
// Bench for motor_pwm_mixer: expected loads are queued when a correction is
// driven and compared when the window boundary applies them.
module tb_motor_pwm_mixer;

    localparam int PER = 250;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] delta;
    logic       delta_valid;
    logic       pwm_left, pwm_right, sat_left, sat_right, period_start;
    logic [7:0] duty_left, duty_right;
    logic [1:0] state;

    typedef struct {
        int dl;
        int dr;
        int sl;
        int sr;
    } load_t;

    load_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    motor_pwm_mixer u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .delta        (delta),
        .delta_valid  (delta_valid),
        .pwm_left     (pwm_left),
        .pwm_right    (pwm_right),
        .duty_left    (duty_left),
        .duty_right   (duty_right),
        .sat_left     (sat_left),
        .sat_right    (sat_right),
        .period_start (period_start),
        .state        (state)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d);
        delta       = 8'(d);
        delta_valid = 1'b1;
        tick();
        delta_valid = 1'b0;
    endtask

    task automatic push(input int dl, input int dr, input int sl, input int sr);
        load_t e;
        e.dl = dl;
        e.dr = dr;
        e.sl = sl;
        e.sr = sr;
        exp_q.push_back(e);
    endtask

    // Step until the next period_start pulse, bounded by a cycle budget.
    task automatic wait_ps();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < PER + 20);
        check_eq("period_start_seen", int'(period_start), 1);
    endtask

    task automatic load_check(input string tag);
        load_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_nonempty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_duty_left"}, int'(duty_left), e.dl);
        check_eq({tag, "_duty_right"}, int'(duty_right), e.dr);
        check_eq({tag, "_sat_left"}, int'(sat_left), e.sl);
        check_eq({tag, "_sat_right"}, int'(sat_right), e.sr);
    endtask

    // Count high cycles on both outputs across one full window.
    task automatic count_window(input string tag, input int exp_l, input int exp_r);
        int hl = 0;
        int hr = 0;
        for (int i = 0; i < PER; i++) begin
            hl += int'(pwm_left);
            hr += int'(pwm_right);
            tick();
        end
        check_eq({tag, "_high_left"}, hl, exp_l);
        check_eq({tag, "_high_right"}, hr, exp_r);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        delta       = 8'd0;
        delta_valid = 1'b0;
        tick(3);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_pwm_left", int'(pwm_left), 0);
        check_eq("rst_duty_left", int'(duty_left), 0);
        check_eq("rst_period_start", int'(period_start), 0);
        rst = 1'b0;
        tick();

        // Plain mix.
        enable = 1'b1;
        tick();
        check_eq("run_state", int'(state), 1);
        check_eq("run_duty_before_load", int'(duty_left), 0);
        send(20);
        push(170, 130, 0, 0);
        wait_ps();
        load_check("d20");
        count_window("d20", 170, 130);

        // Saturation both ways.
        send(127);
        push(250, 23, 1, 0);
        wait_ps();
        load_check("d127");
        count_window("d127", 250, 23);
        send(-128);
        push(22, 250, 0, 1);
        wait_ps();
        load_check("dm128");

        // Last write wins; boundary-cycle strobe waits a window.
        send(10);
        send(-10);
        push(140, 160, 0, 0);
        tick(247);
        send(5);
        check_eq("lww_period_start", int'(period_start), 1);
        load_check("lww");
        push(155, 145, 0, 0);
        wait_ps();
        load_check("late");

        // Watchdog: eight silent boundaries.
        for (int i = 0; i < 8; i++) begin
            check_eq("pre_timeout_state", int'(state), 1);
            wait_ps();
        end
        check_eq("timeout_state", int'(state), 2);
        check_eq("timeout_duty_left", int'(duty_left), 0);
        check_eq("timeout_duty_right", int'(duty_right), 0);
        check_eq("timeout_pwm_left", int'(pwm_left), 0);
        send(0);
        check_eq("recover_state", int'(state), 1);
        push(150, 150, 0, 0);
        wait_ps();
        load_check("recover");

        // Enable drop mid-window.
        send(20);
        push(170, 130, 0, 0);
        wait_ps();
        load_check("pre_drop");
        tick(100);
        check_eq("drop_pwm_before", int'(pwm_left), 1);
        enable = 1'b0;
        tick();
        check_eq("drop_pwm_left", int'(pwm_left), 0);
        check_eq("drop_pwm_right", int'(pwm_right), 0);
        check_eq("drop_state", int'(state), 0);
        check_eq("drop_duty_left", int'(duty_left), 0);
        enable = 1'b1;
        tick();
        begin
            int n = 0;
            check_eq("reen_state", int'(state), 1);
            while (!period_start && n < PER + 20) begin
                check_eq("reen_pwm_left", int'(pwm_left), 0);
                tick();
                n++;
            end
            check_eq("reen_window_len", n, PER);
            check_eq("reen_duty_left", int'(duty_left), 0);
        end

        // Reset mid-window.
        send(20);
        push(170, 130, 0, 0);
        wait_ps();
        load_check("pre_rst");
        tick(200);
        rst = 1'b1;
        tick();
        check_eq("mrst_state", int'(state), 0);
        check_eq("mrst_pwm_left", int'(pwm_left), 0);
        check_eq("mrst_pwm_right", int'(pwm_right), 0);
        check_eq("mrst_duty_left", int'(duty_left), 0);
        check_eq("mrst_duty_right", int'(duty_right), 0);
        check_eq("mrst_sat_left", int'(sat_left), 0);
        check_eq("mrst_period_start", int'(period_start), 0);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_pwm_mixer.md
Name: motor_pwm_mixer

Overview:
- Downstream consumer of the PID correction term `delta`, an 8-bit two's-complement value.
- Mixes `delta` into a fixed base speed: left = BASE + delta, right = BASE − delta.
- Saturates both duties to [0, PERIOD] and generates two edge-aligned PWM outputs for the left/right motor drivers.
- New duties take effect only at PWM period boundaries, so there are no mid-period glitches.
- A watchdog stops both motors if the PID stage goes silent.

Parameters:
- PERIOD, 250: PWM window length in clk cycles; counter runs 0..PERIOD-1.
- BASE_SPEED, 150: nominal duty for both motors (0..PERIOD).
- TIMEOUT_PERIODS, 8: consecutive windows with no delta_valid before forced stop.
- DUTY_W, 8: width of duty outputs; must satisfy 2^DUTY_W > PERIOD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  motor run enable.
- delta  in  8  signed PID correction.
- delta_valid  in  1  single-cycle strobe; delta is sampled when high.
- pwm_left  out  1  left motor PWM.
- pwm_right  out  1  right motor PWM.
- duty_left  out  DUTY_W  active left duty.
- duty_right  out  DUTY_W  active right duty.
- sat_left  out  1  left duty was clamped at last load.
- sat_right  out  1  right duty was clamped at last load.
- period_start  out  1  one-cycle pulse on each window boundary.
- state  out  2  STOP=0, RUN=1, TIMEOUT=2.

Behaviour:
- Reset (clk edge with rst=1):
  - Counter, pending and active duties, pwm_*, sat_*, period_start, miss counter and pending_valid all go to 0.
  - state goes to STOP.
  - Reset overrides everything, including mid-window operation.
- Arithmetic:
  - Sign-extend delta to DUTY_W+2 bits; sum_l = BASE_SPEED + delta, sum_r = BASE_SPEED − delta.
  - Clamp: a result < 0 becomes 0; a result > PERIOD becomes PERIOD. The corresponding sat_* is 1 if clamped, else 0.
- Capture: on delta_valid, clamped sums go to the pending registers and pending_valid is set to 1. Last write wins within a window.
- Boundary:
  - The boundary is the cycle where the counter equals PERIOD-1 in RUN or TIMEOUT. The counter then wraps to 0 and period_start=1 on the following cycle.
  - At the boundary, if pending_valid=1: active duties and sat_* load from pending, pending_valid clears, miss counter clears.
  - Otherwise the active duties are held and the miss counter increments.
- Same-cycle capture and boundary: a delta_valid on the boundary cycle is NOT used for that load. It lands in pending for the next window, and does not count as a miss.
- PWM output: pwm_* are registered. pwm_x=1 for exactly duty_x cycles at the start of each window, starting the cycle period_start is high. duty=0 means constantly low; duty=PERIOD means constantly high.
- FSM:
  - STOP: counter held at 0; pwm_*=0; active duties=0; pending_valid=0; delta_valid ignored. enable=1 moves to RUN next cycle with the counter at 0.
  - RUN: normal operation. Active duties stay 0 until the first valid load.
  - RUN→TIMEOUT: at the boundary where the miss counter reaches TIMEOUT_PERIODS. At that boundary, active duties and sat_* are forced to 0.
  - TIMEOUT: the counter keeps running and pwm_*=0. Any delta_valid moves to RUN next cycle, and the captured value loads at the next boundary.
  - enable=0 in any state: STOP next cycle; pwm_* are 0 from that cycle.
- Latency: from a delta_valid to the new duty appearing on pwm_* = cycles to the next boundary + 1. The maximum is PERIOD + 1.

Decomposition:
- Shared package motor_pkg holds:
  - the state enum (STOP/RUN/TIMEOUT, 2 bits);
  - default PERIOD, BASE_SPEED and DUTY_W constants;
  - a clamp function shared with future speed stages.
- One sub-module, pwm_channel: takes counter, duty and enable and produces the registered pwm bit. It is instantiated twice.

Test Plan:
- Reset, enable=1, delta=+20 valid: at the next boundary duty_left=170 and duty_right=130; pwm_left is high for 170 cycles of the 250-cycle window; sat_*=0.
- delta=+127: duty_left=250 (pwm_left constantly high), sat_left=1, duty_right=23. Then delta=-128: duty_left=22, duty_right=250, sat_right=1.
- Two valids in one window (+10, then −10) plus one valid on the boundary cycle (+5):
  - the first load uses −10 (duty_left=140);
  - the +5 loads at the following boundary (duty_left=155).
- One valid, then silence: after 8 boundaries with no valid, state=TIMEOUT and duties are 0. Then delta=0 valid: state=RUN, and at the next boundary duty_left=duty_right=150.
- enable dropped mid-window at counter=100 with duty=170: the next cycle shows pwm_*=0, state=STOP, counter=0. Re-enabling gives duty 0 until a new valid loads.
- rst asserted at counter=200 while in RUN: the next cycle shows all outputs 0 and state=STOP.
